// File: rtl/fhg_pkg.sv
// Shared constants, arbiter state type and round-robin search for the
// fhg TX arbiter.
package fhg_pkg;

    localparam int DATA_WIDTH = 1024;
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PKT_SIZE   = 8192;
    localparam int MAX_BEATS  = PKT_SIZE / KEEP_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DRAIN
    } arb_state_t;

    // First set bit of req searching upward from ptr+1, wrapping modulo n.
    function automatic logic [2:0] rr_next(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        int         j;
        logic [2:0] res;
        res = ptr;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                j = (int'(ptr) + k) % n;
                if (req[j[2:0]]) res = j[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fhg_axis_reg_slice.sv
// One-deep AXI-Stream register slice with a skid entry so that in_ready
// is a pure flop output and full throughput holds when out_ready=1.
module fhg_axis_reg_slice #(
    parameter int DW = 1024,
    parameter int KW = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_tdata,
    input  logic [KW-1:0] in_tkeep,
    input  logic          in_tlast,
    input  logic          in_tuser,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_tdata,
    output logic [KW-1:0] out_tkeep,
    output logic          out_tlast,
    output logic          out_tuser,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int W = DW + KW + 2;

    logic [W-1:0] in_bus;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;

    assign in_bus = {in_tdata, in_tkeep, in_tlast, in_tuser};

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid;
                if (in_valid) out_d = in_bus;
            end
        end else if (in_valid && !skid_valid_q) begin
            // Output stalled: park the beat that was already accepted.
            skid_valid_d = 1'b1;
            skid_d       = in_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign {out_tdata, out_tkeep, out_tlast, out_tuser} = out_q;

endmodule

// File: rtl/fhg_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 400G TX adapter.
// Optional per-source/truncation counters: FHG_TX_ARB_STATS_EN.
module fhg_tx_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = fhg_pkg::DATA_WIDTH,
    parameter int PKT_SIZE   = fhg_pkg::PKT_SIZE,
    parameter int MAX_BEATS  = PKT_SIZE / (DATA_WIDTH / 8),
    parameter int BEAT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   s_tdata,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [N_PORTS-1:0]              s_tvalid,
    input  logic [N_PORTS-1:0]              s_tlast,
    input  logic [N_PORTS-1:0]              s_tuser,
    output logic [N_PORTS-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    output logic                            m_tuser,
    input  logic                            m_tready,
    output logic [$clog2(N_PORTS)-1:0]      grant_idx,
    output logic                            trunc_pulse
`ifdef FHG_TX_ARB_STATS_EN
    ,
    output logic [N_PORTS*32-1:0]           pkt_cnt,
    output logic [31:0]                     trunc_cnt
`endif
);

    import fhg_pkg::*;

    localparam int KW = DATA_WIDTH / 8;
    localparam int GW = $clog2(N_PORTS);

    arb_state_t        state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_idx_q, grant_idx_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              trunc_q, trunc_d;
    logic [GW-1:0]     nxt;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KW-1:0]         sel_keep;
    logic                  sl_valid;
    logic                  sl_ready;
    logic                  sl_last;
    logic                  sl_user;

    assign nxt = GW'(rr_next(8'(s_tvalid), 3'(rr_ptr_q), N_PORTS));
    assign sel_data = s_tdata[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep = s_tkeep[int'(grant_idx_q)*KW +: KW];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        beat_d      = beat_q;
        trunc_d     = 1'b0;
        s_tready    = '0;
        sl_valid    = 1'b0;
        sl_last     = 1'b0;
        sl_user     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|s_tvalid) begin
                    grant_idx_d = nxt;
                    rr_ptr_d    = nxt;
                    beat_d      = '0;
                    state_d     = PASS;
                end
            end
            PASS: begin
                s_tready[grant_idx_q] = sl_ready;
                sl_valid = s_tvalid[grant_idx_q];
                sl_last  = s_tlast[grant_idx_q];
                sl_user  = s_tuser[grant_idx_q];
                if (sl_valid && sl_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (s_tlast[grant_idx_q]) begin
                        state_d = IDLE;
                    end else if (beat_q == BEAT_W'(MAX_BEATS - 1)) begin
                        // Cap the packet here; the source's tail is dropped.
                        sl_last = 1'b1;
                        sl_user = 1'b1;
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_tready[grant_idx_q] = 1'b1;
                if (s_tvalid[grant_idx_q] && s_tlast[grant_idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= GW'(N_PORTS - 1);
            grant_idx_q <= '0;
            beat_q      <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_q      <= beat_d;
            trunc_q     <= trunc_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign trunc_pulse = trunc_q;

    fhg_axis_reg_slice #(
        .DW (DATA_WIDTH),
        .KW (KW)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tdata  (sel_data),
        .in_tkeep  (sel_keep),
        .in_tlast  (sl_last),
        .in_tuser  (sl_user),
        .in_valid  (sl_valid),
        .in_ready  (sl_ready),
        .out_tdata (m_tdata),
        .out_tkeep (m_tkeep),
        .out_tlast (m_tlast),
        .out_tuser (m_tuser),
        .out_valid (m_tvalid),
        .out_ready (m_tready)
    );

`ifdef FHG_TX_ARB_STATS_EN
    logic [N_PORTS-1:0][31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0]              trunc_cnt_q, trunc_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (sl_valid && sl_ready && sl_last) begin
            pkt_cnt_d[grant_idx_q] = pkt_cnt_q[grant_idx_q] + 32'd1;
        end
        trunc_cnt_d = trunc_cnt_q + {31'd0, trunc_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_fhg_tx_arbiter.sv
// Directed bench for fhg_tx_arbiter; covers FHG_TX_ARB_STATS_EN when defined.
module tb_fhg_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 1024;
    localparam int KW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid, m_tlast, m_tuser, m_tready;
    logic [1:0]      grant_idx;
    logic            trunc_pulse;
`ifdef FHG_TX_ARB_STATS_EN
    logic [N*32-1:0] pkt_cnt;
    logic [31:0]     trunc_cnt;
`endif

    fhg_tx_arbiter #(.N_PORTS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .m_tready    (m_tready),
        .grant_idx   (grant_idx),
        .trunc_pulse (trunc_pulse)
`ifdef FHG_TX_ARB_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .trunc_cnt   (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks, errors;
    int   src_npkts[N], src_len[N], src_pkt[N], src_beat[N];
    logic src_user[N];
    bit   rdy_toggle, to_flag;
    int   cyc, data_err, keep_err, stall_err, trunc_seen;
    logic [31:0] obs_tag[$];
    int   obs_cyc[$];
    int   obs_grant[$];

    function automatic logic [31:0] mkword(int p, int k, int b);
        return {p[7:0], k[7:0], b[7:0], 8'hA5};
    endfunction

    function automatic logic [31:0] mktag(int p, int k, int b, bit l, bit u);
        return {p[7:0], k[7:0], b[7:0], 6'd0, l, u};
    endfunction

    function automatic logic [KW-1:0] keep_of(int b, int len);
        if (b == len - 1) return {{64{1'b0}}, {64{1'b1}}};
        return '1;
    endfunction

    task automatic drive_srcs();
        for (int p = 0; p < N; p++) begin
            if (src_pkt[p] < src_npkts[p]) begin
                s_tvalid[p] = 1'b1;
                s_tdata[p*DW +: DW] = {32{mkword(p, src_pkt[p], src_beat[p])}};
                s_tkeep[p*KW +: KW] = keep_of(src_beat[p], src_len[p]);
                s_tlast[p] = (src_beat[p] == src_len[p] - 1);
                s_tuser[p] = src_user[p];
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[p*DW +: DW] = '0;
                s_tkeep[p*KW +: KW] = '0;
                s_tlast[p] = 1'b0;
                s_tuser[p] = 1'b0;
            end
        end
    endtask

    task automatic clear_obs();
        obs_tag.delete();
        obs_cyc.delete();
        obs_grant.delete();
        data_err = 0;
        keep_err = 0;
        stall_err = 0;
        trunc_seen = 0;
        cyc = 0;
    endtask

    task automatic clear_srcs();
        for (int p = 0; p < N; p++) begin
            src_npkts[p] = 0;
            src_len[p] = 1;
            src_pkt[p] = 0;
            src_beat[p] = 0;
            src_user[p] = 1'b0;
        end
        drive_srcs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_tready = 1'b1;
        rdy_toggle = 1'b0;
        clear_srcs();
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
    endtask

    task automatic run_until(int max_cyc, int stop_port, int stop_beat);
        int n, idle, pp;
        bit all_done, prev_stall;
        logic [N-1:0] acc;
        logic [DW-1:0] pd;
        logic [KW-1:0] pk;
        logic pl, pu;
        logic [31:0] w;
        n = 0;
        idle = 0;
        to_flag = 1'b0;
        prev_stall = 1'b0;
        pd = '0; pk = '0; pl = 1'b0; pu = 1'b0;
        while (1) begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            if (prev_stall && (!m_tvalid || m_tdata !== pd || m_tkeep !== pk ||
                               m_tlast !== pl || m_tuser !== pu))
                stall_err++;
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata; pk = m_tkeep; pl = m_tlast; pu = m_tuser;
            if (trunc_pulse) trunc_seen++;
            if (m_tvalid && m_tready) begin
                w = m_tdata[31:0];
                pp = int'(w[31:24]);
                obs_tag.push_back({w[31:8], 6'd0, m_tlast, m_tuser});
                obs_cyc.push_back(cyc);
                obs_grant.push_back(int'(grant_idx));
                if (m_tdata !== {32{w}}) data_err++;
                if (pp < N) begin
                    if (m_tkeep !== keep_of(int'(w[15:8]), src_len[pp])) keep_err++;
                end else begin
                    keep_err++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            n++;
            for (int p = 0; p < N; p++) begin
                if (acc[p]) begin
                    src_beat[p]++;
                    if (src_beat[p] == src_len[p]) begin
                        src_beat[p] = 0;
                        src_pkt[p]++;
                    end
                end
            end
            if (rdy_toggle) m_tready = !m_tready;
            drive_srcs();
            if (stop_port >= 0) begin
                if (src_beat[stop_port] == stop_beat) break;
            end
            all_done = 1'b1;
            for (int p = 0; p < N; p++)
                if (src_pkt[p] < src_npkts[p]) all_done = 1'b0;
            idle = all_done ? idle + 1 : 0;
            if (idle >= 8) break;
            if (n >= max_cyc) begin
                to_flag = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        src_npkts[0] = 1;
        src_len[0] = 2;
        drive_srcs();
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, trunc_pulse} !== 4'b0) begin
            errors++;
            $display("FAIL rst_ctrl got %b want 0000", {m_tvalid, m_tlast, m_tuser, trunc_pulse});
        end
        checks++;
        if (m_tdata !== '0 || m_tkeep !== '0) begin
            errors++;
            $display("FAIL rst_data got %h/%h want 0", m_tdata[31:0], m_tkeep[15:0]);
        end
        checks++;
        if (s_tready !== '0) begin
            errors++;
            $display("FAIL rst_ready got %b want 0000", s_tready);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL rst_grant got %0d want 0", grant_idx);
        end
    endtask

    task automatic test_single_port();
        int gap;
        do_reset();
        src_npkts[0] = 3;
        src_len[0] = 4;
        drive_srcs();
        rst_n = 1'b1;
        run_until(200, -1, 0);
        checks++;
        if (to_flag !== 1'b0) begin
            errors++;
            $display("FAIL single_timeout got %b want 0", to_flag);
        end
        checks++;
        if (obs_tag.size() != 12) begin
            errors++;
            $display("FAIL single_count got %0d want 12", obs_tag.size());
        end
        for (int i = 0; i < obs_tag.size(); i++) begin
            checks++;
            if (obs_tag[i] !== mktag(0, i / 4, i % 4, (i % 4) == 3, 1'b0)) begin
                errors++;
                $display("FAIL single_beat%0d got %h want %h", i, obs_tag[i],
                         mktag(0, i / 4, i % 4, (i % 4) == 3, 1'b0));
            end
            checks++;
            if (obs_grant[i] != 0) begin
                errors++;
                $display("FAIL single_grant%0d got %0d want 0", i, obs_grant[i]);
            end
            if (i > 0) begin
                gap = ((i % 4) == 0) ? 2 : 1;
                checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != gap) begin
                    errors++;
                    $display("FAIL single_gap%0d got %0d want %0d", i,
                             obs_cyc[i] - obs_cyc[i-1], gap);
                end
            end
        end
        checks++;
        if (data_err + keep_err != 0) begin
            errors++;
            $display("FAIL single_payload got %0d errs want 0", data_err + keep_err);
        end
    endtask

    task automatic test_round_robin();
        int p;
        do_reset();
        for (int q = 0; q < N; q++) begin
            src_npkts[q] = 2;
            src_len[q] = 2;
        end
        src_user[3] = 1'b1;
        drive_srcs();
        rst_n = 1'b1;
        run_until(300, -1, 0);
        checks++;
        if (to_flag !== 1'b0 || obs_tag.size() != 16) begin
            errors++;
            $display("FAIL rr_count got %0d to=%b want 16", obs_tag.size(), to_flag);
        end
        for (int i = 0; i < obs_tag.size(); i++) begin
            p = (i / 2) % 4;
            checks++;
            if (obs_tag[i] !== mktag(p, i / 8, i % 2, (i % 2) == 1, p == 3)) begin
                errors++;
                $display("FAIL rr_beat%0d got %h want %h", i, obs_tag[i],
                         mktag(p, i / 8, i % 2, (i % 2) == 1, p == 3));
            end
        end
        checks++;
        if (data_err + keep_err != 0) begin
            errors++;
            $display("FAIL rr_payload got %0d errs want 0", data_err + keep_err);
        end
`ifdef FHG_TX_ARB_STATS_EN
        for (int q = 0; q < N; q++) begin
            checks++;
            if (pkt_cnt[q*32 +: 32] !== 32'd2) begin
                errors++;
                $display("FAIL rr_pktcnt%0d got %0d want 2", q, pkt_cnt[q*32 +: 32]);
            end
        end
        checks++;
        if (trunc_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rr_trunccnt got %0d want 0", trunc_cnt);
        end
`endif
    endtask

    task automatic test_truncation();
        logic [31:0] exp;
        do_reset();
        src_npkts[1] = 1;
        src_len[1] = 70;
        src_npkts[2] = 1;
        src_len[2] = 3;
        drive_srcs();
        rst_n = 1'b1;
        run_until(400, -1, 0);
        checks++;
        if (to_flag !== 1'b0 || src_pkt[1] != 1) begin
            errors++;
            $display("FAIL trunc_drain got pkt=%0d to=%b want 1/0", src_pkt[1], to_flag);
        end
        checks++;
        if (obs_tag.size() != 67) begin
            errors++;
            $display("FAIL trunc_count got %0d want 67", obs_tag.size());
        end
        for (int i = 0; i < obs_tag.size(); i++) begin
            if (i < 64) exp = mktag(1, 0, i, i == 63, i == 63);
            else exp = mktag(2, 0, i - 64, (i - 64) == 2, 1'b0);
            checks++;
            if (obs_tag[i] !== exp) begin
                errors++;
                $display("FAIL trunc_beat%0d got %h want %h", i, obs_tag[i], exp);
            end
        end
        if (obs_tag.size() > 64) begin
            checks++;
            if (obs_cyc[64] - obs_cyc[63] != 8) begin
                errors++;
                $display("FAIL trunc_gap got %0d want 8", obs_cyc[64] - obs_cyc[63]);
            end
        end
        checks++;
        if (trunc_seen != 1) begin
            errors++;
            $display("FAIL trunc_pulse got %0d want 1", trunc_seen);
        end
        checks++;
        if (data_err + keep_err != 0) begin
            errors++;
            $display("FAIL trunc_payload got %0d errs want 0", data_err + keep_err);
        end
`ifdef FHG_TX_ARB_STATS_EN
        checks++;
        if (trunc_cnt !== 32'd1) begin
            errors++;
            $display("FAIL trunc_cnt got %0d want 1", trunc_cnt);
        end
        checks++;
        if (pkt_cnt[1*32 +: 32] !== 32'd1 || pkt_cnt[2*32 +: 32] !== 32'd1) begin
            errors++;
            $display("FAIL trunc_pktcnt got %0d/%0d want 1/1",
                     pkt_cnt[1*32 +: 32], pkt_cnt[2*32 +: 32]);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        src_npkts[0] = 1;
        src_len[0] = 10;
        drive_srcs();
        rdy_toggle = 1'b1;
        rst_n = 1'b1;
        run_until(200, -1, 0);
        rdy_toggle = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (to_flag !== 1'b0 || obs_tag.size() != 10) begin
            errors++;
            $display("FAIL bp_count got %0d to=%b want 10", obs_tag.size(), to_flag);
        end
        for (int i = 0; i < obs_tag.size(); i++) begin
            checks++;
            if (obs_tag[i] !== mktag(0, 0, i, i == 9, 1'b0)) begin
                errors++;
                $display("FAIL bp_beat%0d got %h want %h", i, obs_tag[i],
                         mktag(0, 0, i, i == 9, 1'b0));
            end
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stable got %0d changes want 0", stall_err);
        end
        checks++;
        if (data_err + keep_err != 0) begin
            errors++;
            $display("FAIL bp_payload got %0d errs want 0", data_err + keep_err);
        end
    endtask

    task automatic test_reset_mid();
        int lasts;
        do_reset();
        src_npkts[0] = 1;
        src_len[0] = 8;
        drive_srcs();
        rst_n = 1'b1;
        run_until(100, 0, 3);
        checks++;
        if (to_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reach got to=%b want 0", to_flag);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            errors++;
            $display("FAIL mid_outputs got v=%b rdy=%b want 0/0000", m_tvalid, s_tready);
        end
        checks++;
        if (dut.state_q !== fhg_pkg::IDLE) begin
            errors++;
            $display("FAIL mid_state got %0d want %0d", dut.state_q, fhg_pkg::IDLE);
        end
        lasts = 0;
        for (int i = 0; i < obs_tag.size(); i++) lasts += int'(obs_tag[i][1]);
        checks++;
        if (lasts != 0) begin
            errors++;
            $display("FAIL mid_partial got %0d tlast want 0", lasts);
        end
        @(posedge clk);
        #1;
        clear_srcs();
        clear_obs();
        src_npkts[2] = 1;
        src_len[2] = 5;
        drive_srcs();
        rst_n = 1'b1;
        run_until(100, -1, 0);
        checks++;
        if (to_flag !== 1'b0 || obs_tag.size() != 5) begin
            errors++;
            $display("FAIL mid_count got %0d to=%b want 5", obs_tag.size(), to_flag);
        end
        for (int i = 0; i < obs_tag.size(); i++) begin
            checks++;
            if (obs_tag[i] !== mktag(2, 0, i, i == 4, 1'b0)) begin
                errors++;
                $display("FAIL mid_beat%0d got %h want %h", i, obs_tag[i],
                         mktag(2, 0, i, i == 4, 1'b0));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        m_tready = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tvalid = '0;
        s_tlast = '0;
        s_tuser = '0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_truncation();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fhg_tx_arbiter.md
Name: fhg_tx_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single 400G TX path between N CASPER AXI-Stream sources. It sits directly upstream of fhg_axis_adapter and drives its casper_tx_* port. Each grant holds until the source's tlast, so packets are never interleaved. It also enforces a maximum packet length: oversize packets are truncated and flagged, and their tail is drained.

Parameters:
N_PORTS, 4, number of upstream AXIS sources (2..8)
DATA_WIDTH, 1024, tdata width in bits; tkeep width is DATA_WIDTH/8
PKT_SIZE, 8192, maximum packet size in bytes
MAX_BEATS, PKT_SIZE/(DATA_WIDTH/8) = 64, maximum beats per packet
BEAT_W, $clog2(MAX_BEATS+1), beat counter width

Ports:
clk  in  1  single clock, 390.625 MHz
rst_n  in  1  asynchronous, active-low reset
s_tdata  in  N_PORTS*DATA_WIDTH  per-source data, port i at slice [i*DATA_WIDTH +: DATA_WIDTH]
s_tkeep  in  N_PORTS*DATA_WIDTH/8  per-source byte enables
s_tvalid  in  N_PORTS  per-source valid
s_tlast  in  N_PORTS  per-source end of packet
s_tuser  in  N_PORTS  per-source error flag
s_tready  out  N_PORTS  per-source ready
m_tdata  out  DATA_WIDTH  data to fhg_axis_adapter casper_tx_tdata
m_tkeep  out  DATA_WIDTH/8  byte enables to adapter
m_tvalid  out  1  valid to adapter
m_tlast  out  1  end of packet to adapter
m_tuser  out  1  error flag to adapter; 1 means a source error or a truncated packet
m_tready  in  1  ready from adapter
grant_idx  out  $clog2(N_PORTS)  index of the currently granted source (status)
trunc_pulse  out  1  one-cycle pulse when a packet is truncated

Behaviour:
Reset values:
- rst_n=0 asynchronously clears: state=IDLE, rr_ptr=N_PORTS-1, grant_idx=0, beat_cnt=0.
- All s_tready=0. Output slice empties: m_tvalid=0 and m_tdata/m_tkeep/m_tlast/m_tuser=0. trunc_pulse=0.
- Reset asserted mid-packet discards the partial packet. No tlast is emitted for it.

State machine: IDLE, PASS, DRAIN.
- IDLE: all s_tready=0. If any s_tvalid is 1, choose the first asserted index searching from rr_ptr+1 upward with wrap-around modulo N_PORTS. Register it into grant_idx, set rr_ptr=grant_idx, clear beat_cnt, and move to PASS. Arbitration costs exactly one bubble cycle per packet.
- PASS: s_tready[grant_idx] = slice input ready. All other s_tready=0.
  - On each accepted beat, beat_cnt increments.
  - Accepted beat with s_tlast=1: forward as-is and return to IDLE.
  - Accepted beat with s_tlast=0 and beat_cnt==MAX_BEATS-1: forward it with m_tlast=1 and m_tuser=1, pulse trunc_pulse, and go to DRAIN.
  - If s_tvalid drops mid-packet, stay in PASS. The grant is not revoked.
- DRAIN: s_tready[grant_idx]=1 and nothing is forwarded. Return to IDLE on an accepted s_tlast.
- Simultaneous requests: the round-robin order guarantees each of N requesters is granted within N packets.
- Single requester: it is re-granted after one bubble.

Output slice:
- One-deep register slice with a skid buffer. Latency from an accepted s_* beat to m_* is 1 cycle.
- m_* outputs hold stable while m_tvalid=1 and m_tready=0.
- Full throughput is sustained when m_tready=1.

Passthrough:
- tkeep and tdata pass unchanged.
- The m_tuser of a normal beat is s_tuser of the granted source, ORed with the truncation flag.

Optional Feature:
FHG_TX_ARB_STATS_EN
- Defined: adds output pkt_cnt [N_PORTS*32] and output trunc_cnt [32].
  - pkt_cnt holds one wrapping 32-bit counter per source. A source's counter increments when that source's packet tlast (or truncated-packet end) is forwarded.
  - trunc_cnt is a 32-bit counter that increments on each trunc_pulse.
  - Both reset to 0 on rst_n=0.
- Undefined: neither port nor any counter exists. Behaviour is otherwise identical.

Decomposition:
Shared package fhg_pkg holds:
- DATA_WIDTH, KEEP_WIDTH, PKT_SIZE and MAX_BEATS constants
- the arbiter state enum arb_state_t {IDLE, PASS, DRAIN}
- the rr_next() function for the round-robin search

One sub-module, fhg_axis_reg_slice: the parameterized skid register slice carrying tdata, tkeep, tlast and tuser.

Test Plan:
1. Only port 0 sends three 4-beat packets with m_tready=1 -> three 4-beat packets appear in order, one bubble cycle between them, grant_idx=0 throughout.
2. All four ports continuously valid, each with 2-beat packets -> grant order is 0,1,2,3,0,… with no interleaving inside any packet.
3. Port 1 sends a 70-beat packet with no tlast before beat 70 -> 64 beats forwarded, beat 64 has m_tlast=1 and m_tuser=1, trunc_pulse fires once, beats 65–70 are consumed with no output, and the next grant follows.
4. m_tready toggles 1,0,1,0 during a 10-beat packet -> no beat is lost or duplicated and m_* stays stable while stalled; the output matches the input sequence.
5. rst_n is asserted at beat 3 of 8 and released -> m_tvalid=0 immediately, state is IDLE, and the next packet from port 2 is forwarded complete.
6. With FHG_TX_ARB_STATS_EN defined, run scenarios 2 and 3 -> pkt_cnt is 2 per port after 8 packets (scenario 2), and trunc_cnt=1 with pkt_cnt[1] incremented once (scenario 3).
